mux_scan_sel: RTL

- Parametrised, registered N-channel, M-bit-wide selector; successor to the single-bit 7:1 switch mux.
- Adds three sequenced modes:
  - continuous channel scanning with a programmable dwell time;
  - a one-shot sweep with start/busy/done handshake;
  - a hold/freeze mode.
- Sits between switch/data sources and LED/HEX display or serial-out logic.

---
 rtl/mux_scan_sel.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mux_scan_sel.sv
// Registered N-channel selector with manual, continuous-scan, one-shot sweep and hold modes.
module mux_scan_sel #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 7,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned DWELL    = 3
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel,
  input  logic [1:0]                mode,
  input  logic                      start,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned NSLOT = 1 << SEL_W;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
  localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);

  localparam logic [1:0] M_MAN   = 2'b00;
  localparam logic [1:0] M_SCAN  = 2'b01;
  localparam logic [1:0] M_SWEEP = 2'b10;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_e;

  // Unpacked view of the channels, padded with zeros up to the full select range.
  logic [WIDTH-1:0] chan [NSLOT];

  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_chan
      if (gi < CHANNELS) begin : g_real
        assign chan[gi] = data_in[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign chan[gi] = '0;
      end
    end
  endgenerate

  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [1:0]       mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  state_e           state_q, state_d;
  logic             load;
  logic [SEL_W-1:0] ch_inc_c;

  // Next channel in scan order, wrapping after the last populated channel.
  assign ch_inc_c = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);

  // Mode sequencing, sweep FSM next-state and output register loads.
  always_comb begin
    data_d  = data_q;
    ch_d    = ch_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    state_d = state_q;
    load    = 1'b0;

    case (mode)
      M_MAN: begin
        state_d = S_IDLE;
        mode_d  = M_MAN;
        valid_d = 1'b1;
        load    = 1'b1;
        ch_d    = (32'(sel) < CHANNELS) ? sel : '0;
      end
      M_SCAN: begin
        state_d = S_IDLE;
        mode_d  = M_SCAN;
        valid_d = 1'b1;
        load    = 1'b1;
        if (mode_q != M_SCAN) begin
          ch_d    = '0;
          dwell_d = '0;
        end else if (dwell_q == LAST_DW) begin
          ch_d    = ch_inc_c;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + DW_W'(1);
        end
      end
      M_SWEEP: begin
        mode_d = M_SWEEP;
        if (state_q == S_IDLE) begin
          if (start) begin
            state_d = S_SWEEP;
            ch_d    = '0;
            dwell_d = '0;
            valid_d = 1'b1;
            load    = 1'b1;
          end
        end else if (dwell_q == LAST_DW) begin
          if (ch_q == LAST_CH) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            dwell_d = '0;
          end else begin
            ch_d    = ch_inc_c;
            dwell_d = '0;
            load    = 1'b1;
          end
        end else begin
          dwell_d = dwell_q + DW_W'(1);
          load    = 1'b1;
        end
      end
      default: begin
        // Hold: everything keeps its value, done stays low.
      end
    endcase

    if (load) begin
      data_d = chan[ch_d];
    end
    busy_d = (state_d == S_SWEEP);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_q  <= '0;
      ch_q    <= '0;
      dwell_q <= '0;
      mode_q  <= M_MAN;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      data_q  <= data_d;
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign data_out  = data_q;
  assign cur_ch    = ch_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
